// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port register file with combinational reads, write-through
//             bypass, optional hard-wired zero entry and a self-clearing
//             controller that zeroes the array one entry per cycle.
//  Ports    : clk    - sole clock, all state updates on rising edge
//             rst    - synchronous active-high reset (restarts the clear)
//             clr    - request to re-zero the array (honoured only in RUN)
//             wen    - per-port write enable            [NWRITE]
//             wsel   - per-port write address, port p at [p*AW +: AW]
//             wdata  - per-port write data,    port p at [p*XLEN +: XLEN]
//             rsel   - per-lane read address, packed as wsel
//             rdata  - per-lane read data,    packed as wdata
//             ready  - array initialised and accepting writes
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [NWRITE-1:0]        wen,
    input  logic [NWRITE*AW-1:0]     wsel,
    input  logic [NWRITE*XLEN-1:0]   wdata,
    input  logic [NREAD*AW-1:0]      rsel,
    output logic [NREAD*XLEN-1:0]    rdata,
    output logic                     ready
);

    localparam logic [0:0]    c_ST_CLEAR = 1'b0;
    localparam logic [0:0]    c_ST_RUN   = 1'b1;
    localparam logic [AW-1:0] c_LAST     = AW'(DEPTH - 1);

    logic [XLEN-1:0]   r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [AW-1:0]     r_cnt;
    logic [AW-1:0]     w_cnt_nxt;
    logic              w_run;
    logic [NWRITE-1:0] w_commit;

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next-state logic. The counter saturates at the last
    // entry so it never wraps; leaving CLEAR is keyed off that value.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_CLEAR: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            default: begin
                if (clr) begin
                    w_state_nxt = c_ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Controller: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_run = (r_state == c_ST_RUN);
        ready = w_run;
    end

    // A write commits only in RUN, outside reset, and not to the hard-wired
    // zero entry. The same qualifier drives the read bypass so the bypass
    // never shows data the array will not hold.
    always_comb begin
        w_commit = '0;
        for (int p = 0; p < NWRITE; p++) begin
            w_commit[p] = wen[p] && w_run && !rst &&
                          !((ZERO_REG != 0) && (wsel[p*AW +: AW] == '0));
        end
    end

    // ------------------------------------------------------------------
    // Storage. Ports are visited in ascending order so the highest port
    // number wins on an address collision. A write committed in the same
    // cycle as clr lands here and is zeroed later by the clear sweep.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run) begin
                r_mem[r_cnt] <= '0;
            end else begin
                for (int p = 0; p < NWRITE; p++) begin
                    if (w_commit[p]) begin
                        r_mem[wsel[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read lanes: array value, overridden by the bypass (higher port
    // last so it wins), then forced to zero in CLEAR or for entry 0.
    // ------------------------------------------------------------------
    generate
        for (genvar r = 0; r < NREAD; r++) begin : g_rd
            logic [AW-1:0]   w_rsel;
            logic [XLEN-1:0] w_lane;

            always_comb begin
                w_rsel = rsel[r*AW +: AW];
                w_lane = r_mem[w_rsel];
                for (int p = 0; p < NWRITE; p++) begin
                    if (w_commit[p] && (wsel[p*AW +: AW] == w_rsel)) begin
                        w_lane = wdata[p*XLEN +: XLEN];
                    end
                end
                if (!w_run || ((ZERO_REG != 0) && (w_rsel == '0))) begin
                    w_lane = '0;
                end
            end

            assign rdata[r*XLEN +: XLEN] = w_lane;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp. Two instances share all
//             inputs: dut 0 with ZERO_REG=1, dut 1 with ZERO_REG=0. Stimulus
//             pushes expected values into a scoreboard queue; a monitor pops
//             and compares them against the DUT outputs on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        clr   = 1'b0;
    logic [1:0]  wen   = '0;
    logic [9:0]  wsel  = '0;
    logic [63:0] wdata = '0;
    logic [9:0]  rsel  = '0;
    logic [63:0] rdata_a;
    logic [63:0] rdata_b;
    logic        ready_a;
    logic        ready_b;

    regfile_mp #(.XLEN(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .wen(wen), .wsel(wsel),
        .wdata(wdata), .rsel(rsel), .rdata(rdata_a), .ready(ready_a)
    );

    regfile_mp #(.XLEN(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(0)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .wen(wen), .wsel(wsel),
        .wdata(wdata), .rsel(rsel), .rdata(rdata_b), .ready(ready_b)
    );

    always #5 clk = ~clk;

    // lane < 0 selects the ready output instead of a read lane
    typedef struct {
        int          dut;
        int          lane;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    exp_t        m_e;
    logic [31:0] m_act;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            if (m_e.lane < 0)
                m_act = {31'b0, (m_e.dut == 0) ? ready_a : ready_b};
            else if (m_e.dut == 0)
                m_act = rdata_a[m_e.lane*32 +: 32];
            else
                m_act = rdata_b[m_e.lane*32 +: 32];
            n_chk++;
            if (m_act !== m_e.exp) begin
                n_fail++;
                $display("FAIL %s: dut%0d lane%0d got %h expected %h",
                         m_e.name, m_e.dut, m_e.lane, m_act, m_e.exp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input int d, input int lane, input logic [31:0] e, input string nm);
        exp_t x;
        x.dut = d; x.lane = lane; x.exp = e; x.name = nm;
        sb.push_back(x);
    endtask

    task automatic exp_rdy(input logic e, input string nm);
        exp_rd(0, -1, {31'b0, e}, nm);
        exp_rd(1, -1, {31'b0, e}, nm);
    endtask

    // same expectation on both instances for a lane
    task automatic exp_both(input int lane, input logic [31:0] e, input string nm);
        exp_rd(0, lane, e, nm);
        exp_rd(1, lane, e, nm);
    endtask

    task automatic set_rsel(input int a0, input int a1);
        rsel[4:0] = a0[4:0];
        rsel[9:5] = a1[4:0];
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wen[p]           = 1'b1;
        wsel[p*5 +: 5]   = a[4:0];
        wdata[p*32 +: 32] = d;
    endtask

    function automatic logic [31:0] fillval(input int a);
        return 32'h1000_0000 | (a * 32'h111);
    endfunction

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        // reset for one cycle, then 32 clear cycles with ready low
        tick();
        rst = 1'b0;
        set_rsel(3, 17);
        for (int i = 1; i <= 32; i++) begin
            exp_rdy(1'b0, "reset_clear_ready");
            exp_both(0, 32'h0, "reset_clear_rd0");
            exp_both(1, 32'h0, "reset_clear_rd1");
            tick();
        end
        exp_rdy(1'b1, "ready_cycle33");
        tick();
        for (int a = 0; a < 32; a++) begin
            set_rsel(a, 31 - a);
            exp_both(0, 32'h0, "post_reset_zero0");
            exp_both(1, 32'h0, "post_reset_zero1");
            tick();
        end

        // bypass then stored value
        wr(0, 5, 32'hDEAD_BEEF);
        set_rsel(5, 6);
        exp_both(0, 32'hDEAD_BEEF, "bypass_p0");
        exp_both(1, 32'h0, "bypass_other_lane");
        tick();
        wen = '0;
        exp_both(0, 32'hDEAD_BEEF, "stored_p0");
        tick();

        // same-address collision: port 1 wins
        wr(0, 7, 32'h11);
        wr(1, 7, 32'h22);
        set_rsel(7, 7);
        exp_both(0, 32'h22, "collide_bypass0");
        exp_both(1, 32'h22, "collide_bypass1");
        tick();
        wen = '0;
        set_rsel(7, 5);
        exp_both(0, 32'h22, "collide_stored");
        exp_both(1, 32'hDEAD_BEEF, "lane1_independent");
        tick();

        // entry 0: hard zero in dut0, ordinary entry in dut1
        wr(0, 0, 32'h55);
        set_rsel(0, 0);
        exp_rd(0, 0, 32'h0,  "zero_reg_bypass");
        exp_rd(1, 0, 32'h55, "nozero_bypass");
        tick();
        wen = '0;
        exp_rd(0, 1, 32'h0,  "zero_reg_stored");
        exp_rd(1, 1, 32'h55, "nozero_stored");
        tick();

        // fill 1..31 and spot-check
        for (int a = 1; a < 32; a++) begin
            wr(0, a, fillval(a));
            tick();
        end
        wen = '0;
        set_rsel(3, 31);
        exp_both(0, 32'h1000_0333, "fill_addr3");
        exp_both(1, 32'h1000_210F, "fill_addr31");
        #1;
        n_chk++;
        if (rdata_a[31:0] !== 32'h1000_0333) begin
            n_fail++;
            $display("FAIL direct_fill_addr3: got %h expected %h", rdata_a[31:0], 32'h1000_0333);
        end
        n_chk++;
        if (rdata_b[63:32] !== 32'h1000_210F) begin
            n_fail++;
            $display("FAIL direct_fill_addr31: got %h expected %h", rdata_b[63:32], 32'h1000_210F);
        end
        n_chk++;
        if (ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_ready_a: got %b expected 1", ready_a);
        end
        n_chk++;
        if (ready_b !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_ready_b: got %b expected 1", ready_b);
        end
        tick();

        // clr with a same-cycle write: write visible this cycle only
        clr = 1'b1;
        wr(0, 9, 32'h0000_0099);
        set_rsel(9, 9);
        exp_rdy(1'b1, "clr_cycle_ready");
        exp_both(0, 32'h99, "clr_cycle_bypass");
        tick();
        clr = 1'b0;
        wen = '0;
        for (int k = 1; k <= 32; k++) begin
            clr = (k == 10);
            set_rsel(k - 1, 32 - k);
            exp_rdy(1'b0, "clr_sweep_ready");
            exp_both(0, 32'h0, "clr_sweep_rd0");
            exp_both(1, 32'h0, "clr_sweep_rd1");
            tick();
        end
        clr = 1'b0;
        exp_rdy(1'b1, "clr_done_ready");
        tick();
        for (int a = 0; a < 32; a++) begin
            set_rsel(a, 31 - a);
            exp_both(0, 32'h0, "post_clr_zero0");
            exp_both(1, 32'h0, "post_clr_zero1");
            tick();
        end

        // reset in the middle of a clear, writes attempted throughout
        wr(0, 4, 32'hA4);
        wr(1, 20, 32'hB20);
        tick();
        wen = '0;
        set_rsel(4, 20);
        exp_both(0, 32'hA4,  "pre_rst_addr4");
        exp_both(1, 32'hB20, "pre_rst_addr20");
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_rsel(25, 26);
        for (int k = 1; k <= 16; k++) begin
            wr(0, 25, 32'h2525_2525);
            wr(1, 26, 32'h2626_2626);
            rst = (k == 16);
            exp_rdy(1'b0, "midclr_ready");
            exp_both(0, 32'h0, "midclr_rd0");
            exp_both(1, 32'h0, "midclr_rd1");
            tick();
        end
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            exp_rdy(1'b0, "after_rst_ready");
            exp_both(0, 32'h0, "after_rst_rd0");
            tick();
        end
        wen = '0;
        exp_rdy(1'b1, "after_rst_ready_high");
        exp_both(0, 32'h0, "clear_write_gone25");
        exp_both(1, 32'h0, "clear_write_gone26");
        tick();
        set_rsel(4, 20);
        exp_both(0, 32'h0, "rst_cleared_addr4");
        exp_both(1, 32'h0, "rst_cleared_addr20");
        tick();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
